// File: rtl/iterative_cipher_core.sv
// iterative_cipher_core: one-round-per-clock S-box/rotate/key-XOR cipher with encrypt/decrypt and valid/ready handshakes
module iterative_cipher_core #(
  parameter int N = 8,
  parameter int ROUNDS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         busy
);
  localparam int CW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] x, k, x_nx, rk, t;
  logic [CW-1:0] cnt;
  logic m, last;
  function automatic logic [1:0] s2(input logic [1:0] g, input logic inv);
    logic [7:0] tab;
    tab = inv ? 8'b10_00_11_01 : 8'b01_11_00_10;
    return tab[{g, 1'b0} +: 2];
  endfunction
  function automatic logic [N-1:0] sub(input logic [N-1:0] v, input logic inv);
    logic [N-1:0] o;
    o = '0;
    for (int i = 0; i < N / 2; i++) o[2*i +: 2] = s2(v[2*i +: 2], inv);
    return o;
  endfunction
  always_comb begin
    rk = k ^ N'(cnt);
    t = m ? x ^ rk : sub(x, 1'b0);
    x_nx = m ? sub({t[0], t[N-1:1]}, 1'b1) : {t[N-2:0], t[N-1]} ^ rk;
    last = m ? cnt == '0 : cnt == LAST;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    if (state == IDLE && in_valid) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && out_ready) state_nx = IDLE;
  end
  // the counter is frozen on the final round so it never wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      k <= '0;
      m <= 1'b0;
      cnt <= '0;
      data_out <= '0;
    end else if (state == IDLE && in_valid) begin
      x <= data_in;
      k <= key;
      m <= mode;
      cnt <= mode ? LAST : '0;
    end else if (state == RUN) begin
      x <= x_nx;
      if (last) data_out <= x_nx;
      else cnt <= m ? cnt - 1'b1 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_iterative_cipher_core.sv
// tb_iterative_cipher_core: scoreboard bench for iterative_cipher_core (N=8, ROUNDS=3)
module tb_iterative_cipher_core;
  localparam int N = 8;
  localparam int R = 3;
  logic clk = 0, rst = 1, in_valid = 0, mode = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [N-1:0] data_in = '0, key = '0, data_out;
  int checks = 0, passed = 0;
  logic [N-1:0] sb_q[$];
  iterative_cipher_core #(.N(N), .ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask
  function automatic logic [1:0] sb(input logic [1:0] g);
    case (g)
      2'd0: return 2'd2;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd1;
    endcase
  endfunction
  function automatic logic [N-1:0] enc_m(input logic [N-1:0] p, input logic [N-1:0] kk);
    logic [N-1:0] v, s;
    v = p;
    for (int r = 0; r < R; r++) begin
      for (int i = 0; i < N / 2; i++) s[2*i +: 2] = sb(v[2*i +: 2]);
      v = {s[N-2:0], s[N-1]} ^ kk ^ N'(r);
    end
    return v;
  endfunction
  task automatic send(input logic [N-1:0] d, input logic [N-1:0] kk, input logic md, input logic [N-1:0] exp);
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    data_in = d;
    key = kk;
    mode = md;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    data_in = N'($urandom);
    key = N'($urandom);
    mode = 1'($urandom);
    sb_q.push_back(exp);
  endtask
  task automatic recv(input int stall);
    int n;
    logic [N-1:0] exp;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, R);
    check("sb_nonempty", sb_q.size() != 0, 1);
    exp = sb_q.size() != 0 ? sb_q.pop_front() : '0;
    check("data_out", data_out, exp);
    if (stall > 0) begin
      in_valid = 1;
      data_in = 8'h12;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", data_out, exp);
      check("stall_ready", in_ready, 0);
    end
    in_valid = 0;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    check("ret_valid", out_valid, 0);
    check("ret_busy", busy, 0);
    check("ret_ready", in_ready, 1);
  endtask
  initial begin
    logic [N-1:0] p, kk, c;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", data_out, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_ready", in_ready, 1);
    send(8'hAA, 8'hCC, 0, 8'h60);
    recv(0);
    send(8'h60, 8'hCC, 1, 8'hAA);
    recv(0);
    send(8'h00, 8'h00, 0, 8'h53);
    recv(5);
    send(8'hAA, 8'hCC, 0, 8'h60);
    key = 8'hFF;
    data_in = 8'h12;
    recv(0);
    send(8'h5A, 8'h3C, 0, 8'h00);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_dout", data_out, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 0;
    #1;
    check("arst_ready", in_ready, 1);
    for (int j = 0; j < 6; j++) begin
      p = N'($urandom);
      kk = N'($urandom);
      c = enc_m(p, kk);
      send(p, kk, 0, c);
      recv(0);
      send(c, kk, 1, p);
      recv(j % 2);
    end
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/iterative_cipher_core.md
Name: iterative_cipher_core

Overview:
- Sequential, parametrised successor to the combinational substitution/rotate/key-XOR encryption module.
- Performs one round per clock over a configurable word width and round count.
- Supports both encrypt and decrypt, with valid/ready handshakes on input and output.
- Sits between a data producer and consumer on the secure datapath, one block in flight at a time.

Parameters:
- N, 8, data/key width in bits; even, >= 4.
- ROUNDS, 3, rounds per block; 1..15. Round counter width is clog2(ROUNDS), minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  core can accept a block.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- data_in  in  N  plaintext (encrypt) or ciphertext (decrypt).
- key  in  N  block key; sampled at accept.
- out_valid  out  1  data_out holds a finished result.
- out_ready  in  1  consumer takes the result.
- data_out  out  N  result word.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asserted at any time, including mid-round): state = IDLE; in_ready = 1 after release; out_valid = 0; busy = 0; data_out = 0; round counter, data register, key register and mode register all = 0.
- 2-bit S-box S: 0->2, 1->0, 2->3, 3->1.
- Inverse S-box: 0->1, 1->3, 2->0, 3->2.
- Encrypt round r (r = 0..ROUNDS-1):
  - x = S applied to every 2-bit group x[2i+1:2i].
  - x = rotate-left-by-1(x).
  - x = x ^ (key ^ r), with r zero-extended to N bits.
- Decrypt round r (r = ROUNDS-1 down to 0):
  - x = x ^ (key ^ r).
  - x = rotate-right-by-1(x).
  - x = inverse S applied to every 2-bit group.
- Decrypt is the exact inverse of encrypt for the same key.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch data_in, key and mode; load counter with 0 (encrypt) or ROUNDS-1 (decrypt); go to RUN.
- FSM RUN:
  - in_ready = 0.
  - Each edge applies one round to the data register and steps the counter (+1 encrypt, -1 decrypt).
  - The edge that applies the final round also loads data_out and enters DONE.
- FSM DONE:
  - out_valid = 1; data_out held stable.
  - When out_ready = 1 at an edge: out_valid drops and state returns to IDLE.
  - No new accept in the same cycle as the return to IDLE.
- Latency: accept at edge E0; out_valid first high after edge E_ROUNDS. Throughput: one block per ROUNDS+2 cycles with out_ready held high.
- Mid-RUN changes on data_in, key or mode are ignored. in_valid while busy is not accepted, and the producer holds it.
- out_ready high outside DONE has no effect.
- data_out retains the last result after DONE until the next result or reset.
- ROUNDS = 1: RUN lasts exactly one cycle.
- Round index above 2^N - 1 is impossible by the parameter range. The counter never wraps because the FSM leaves RUN at the final round.

Test Plan:
- Reset: assert rst asynchronously mid-RUN (between edges) -> out_valid = 0, busy = 0, data_out = 0 immediately; in_ready = 1 after release.
- Encrypt (N = 8, ROUNDS = 3): data_in = 0xAA, key = 0xCC, mode = 0 -> out_valid high 3 cycles after accept, data_out = 0x60.
- Decrypt: data_in = 0x60, key = 0xCC, mode = 1 -> data_out = 0xAA.
- Zero vector: data_in = 0x00, key = 0x00, mode = 0 -> data_out = 0x53.
- Backpressure: hold out_ready = 0 for 5 cycles after the 0x53 result -> out_valid and data_out = 0x53 stable; in_ready = 0; new in_valid ignored. Release out_ready -> IDLE next cycle.
- Input isolation: change key to 0xFF and data_in to 0x12 one cycle after accepting 0xAA/0xCC -> result still 0x60.
